// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: FSM state encoding and
// default parameter values.
package spi_reg_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 8;
  localparam int NUM_REGS_DEF    = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_slave_sync.sv
// spi_sync: STAGES-deep flip-flop synchroniser for one asynchronous input.
// RST_VAL is the idle level the chain resets to, so a reset never fabricates
// an edge on the synchronised signal.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the raw input one stage further down the chain every clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // synchroniser flops, reset to the idle level
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI (mode 3, MSB first) write-only register slave.
// A frame is {address, data}; a frame of exactly FRAME_W bits addressing an
// existing register writes it, anything else is rejected with frame_err_o.
// Optional feature: define SPI_REG_READBACK_EN to shift the last written
// {address, register} out on spi_miso_o during the next frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ss high, waiting for a synchronised ss falling edge
// ST_SHIFT  | ss low, sampling MOSI on each synchronised SCK rising edge
// ST_COMMIT | one cycle after ss rose: write register or flag frame error
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       spi_sck_i,
  input  logic                       spi_ss_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_valid_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [DATA_W-1:0]          wr_data_o,
  output logic                       frame_err_o,
  output logic                       busy_o
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  logic sck_s, ss_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_sck_i), .q_o(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_ss_i), .q_o(ss_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_mosi_i), .q_o(mosi_s));

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic                sck_prev_q, sck_prev_d;
  logic                ss_prev_q, ss_prev_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_err_q, frame_err_d;

  logic sck_rise, ss_fall, ss_rise;
  logic start_frame, commit;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_ok;

`ifdef SPI_REG_READBACK_EN
  logic               sck_fall;
  logic [FRAME_W-1:0] miso_sh_q, miso_sh_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [DATA_W-1:0]  rb_data;
  assign sck_fall = ~sck_s & sck_prev_q;
`endif

  assign sck_rise   = sck_s & ~sck_prev_q;
  assign ss_fall    = ~ss_s & ss_prev_q;
  assign ss_rise    = ss_s & ~ss_prev_q;
  assign frame_addr = shreg_q[FRAME_W-1 -: ADDR_W];
  assign frame_data = shreg_q[DATA_W-1:0];
  assign frame_ok   = (bit_cnt_q == CNT_FULL) && ({1'b0, frame_addr} < NUM_REGS_C);

  // FSM next state; a new ss fall in COMMIT goes straight back to SHIFT
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d     = ST_SHIFT;
          start_frame = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit = 1'b1;
        if (ss_fall) begin
          state_d     = ST_SHIFT;
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath: frame capture, commit decision, register file, readback
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    regs_d      = regs_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
`ifdef SPI_REG_READBACK_EN
    miso_sh_d   = miso_sh_q;
    last_addr_d = last_addr_q;
    rb_data     = '0;
`endif

    if (commit) begin
      if (frame_ok) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (frame_addr == ADDR_W'(k)) regs_d[k] = frame_data;
        end
        wr_valid_d = 1'b1;
        wr_addr_d  = frame_addr;
        wr_data_d  = frame_data;
`ifdef SPI_REG_READBACK_EN
        last_addr_d = frame_addr;
`endif
      end else begin
        frame_err_d = 1'b1;
      end
    end

    if (start_frame) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
`ifdef SPI_REG_READBACK_EN
      // use the post-commit view so a frame starting during COMMIT sees it
      for (int k = 0; k < NUM_REGS; k++) begin
        if (last_addr_d == ADDR_W'(k)) rb_data = regs_d[k];
      end
      miso_sh_d = {last_addr_d, rb_data};
`endif
    end else if (state_q == ST_SHIFT && !ss_rise) begin
      if (sck_rise) begin
        shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
`ifdef SPI_REG_READBACK_EN
      // the first SCK fall only opens the frame; the MSB must stay on the
      // line until the master samples it on the following rise
      if (sck_fall && bit_cnt_q != '0) begin
        miso_sh_d = {miso_sh_q[FRAME_W-2:0], 1'b0};
      end
`endif
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      sck_prev_q  <= 1'b1;
      ss_prev_q   <= 1'b1;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
`ifdef SPI_REG_READBACK_EN
      miso_sh_q   <= '0;
      last_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      regs_q      <= regs_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_REG_READBACK_EN
      miso_sh_q   <= miso_sh_d;
      last_addr_q <= last_addr_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != ST_IDLE);

`ifdef SPI_REG_READBACK_EN
  assign spi_miso_o = miso_sh_q[FRAME_W-1];
`else
  assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Testbench for spi_reg_slave (ADDR_W=8, DATA_W=8, NUM_REGS=4). Build with
// SPI_REG_READBACK_EN defined to also check the readback stream.
module tb_spi_reg_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;   // clk cycles per SCK half period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b1;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] regs;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_err;
  logic        busy;

  spi_reg_slave #(
    .ADDR_W(8), .DATA_W(8), .NUM_REGS(4), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .spi_sck_i(sck), .spi_ss_i(ss), .spi_mosi_i(mosi), .spi_miso_o(miso),
    .regs_o(regs), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .frame_err_o(frame_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_write;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] regs;
    int          due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_regs [4];
  logic [7:0] model_last;
  int         checks = 0;
  int         fails  = 0;

  function automatic logic [31:0] model_flat();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) model_regs[k] = 8'h00;
    model_last = 8'h00;
  endtask

  // monitor: every write/error pulse must match the oldest expected frame
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_valid || frame_err) begin
        check("pulse_exclusive", 32'(wr_valid & frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_pulse: wr_valid=%0b frame_err=%0b with no frame pending", wr_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_wr_valid", 32'(wr_valid), 32'(e.is_write));
          check("pulse_latency", 32'(cyc), 32'(e.due));
          if (e.is_write) begin
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
          end
          check("regs_at_pulse", regs, e.regs);
        end
      end
    end
  end

  // drive one frame of n bits (bits[n-1] first), then queue the expected outcome
  task automatic send_frame(input logic [31:0] bits, input int n);
    exp_t        e;
    logic [31:0] rb;
    logic [31:0] rb_exp;
    logic [7:0]  a;
    rb_exp = 32'({model_last, model_regs[model_last[1:0]]});
    rb = '0;
    @(negedge clk) ss = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = n - 1; i >= 0; i--) begin
      sck  = 1'b0;
      mosi = bits[i];
      repeat (HALF) @(negedge clk);
      rb  = {rb[30:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    ss = 1'b1;
    a = bits[15:8];
    e.is_write = (n == 16) && (a < 8'd4);
    e.addr     = a;
    e.data     = bits[7:0];
    if (e.is_write) begin
      model_regs[a[1:0]] = bits[7:0];
      model_last         = a;
    end
    e.regs = model_flat();
    e.due  = cyc + SYNC_STAGES + 2;
    exp_q.push_back(e);
    repeat (6) @(negedge clk);
    check("busy_after_commit", 32'(busy), 32'd0);
`ifdef SPI_REG_READBACK_EN
    if (n <= 16) rb_exp = rb_exp >> (16 - n);
    else         rb_exp = rb_exp << (n - 16);
    check("miso_stream", rb, rb_exp);
`else
    check("miso_tied_low", rb, 32'd0);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_regs"}, regs, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
  endtask

  initial begin
    logic [32:0] w;
    int          lens [6];
    int          n;
    lens = '{16, 16, 16, 9, 15, 17};
    model_reset();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(32'h0201, 16);           // write reg 2
    send_frame(32'h00A5, 9);            // aborted after 9 bits
    send_frame(32'h0755, 16);           // address out of range
    send_frame(32'h1_0155, 17);         // overrun
    send_frame(32'h01A5, 16);
    send_frame(32'h0000, 16);           // reads back 01A5, clears reg 0

    // reset in the middle of a frame
    @(negedge clk) ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 8; i--) begin
      w = 33'h0333;
      sck  = 1'b0;
      mosi = w[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst = 1'b1;
    ss  = 1'b1;
    sck = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("mid_frame_reset");
    model_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(32'h0333, 16);

    // back-to-back frames
    send_frame(32'h0011, 16);
    send_frame(32'h0122, 16);

    for (int t = 0; t < 24; t++) begin
      n = lens[$urandom_range(0, 5)];
      w = 33'($urandom);
      if (n == 16) w = {17'd0, 8'($urandom_range(0, 5)), 8'($urandom)};
      send_frame(w[31:0], n);
    end

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
